// File: rtl/eb_cla_adder.sv
`timescale 1ns/1ps
// 8-bit two-level carry-lookahead adder. Y/Cout/Ovf are combinational; Y_q/Cout_q/Ovf_q register them
// with one cycle of latency. No flow control: the registers load every cycle.
module eb_cla_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic [7:0] Y,
   output logic       Cout,
   output logic       Ovf,
   output logic [7:0] Y_q,
   output logic       Cout_q,
   output logic       Ovf_q
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;
   logic       grp_g0, grp_p0, grp_g1, grp_p1;

   assign g = A & B;
   assign p = A ^ B;

   // Group 0: every carry is expanded back to Cin so nothing ripples between bits.
   assign c[0]   = Cin;
   assign c[1]   = g[0] | (p[0] & Cin);
   assign c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
   assign c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
   assign grp_g0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign grp_p0 = &p[3:0];

   // Second level: group carries straight from the group terms.
   assign c[4]   = grp_g0 | (grp_p0 & Cin);
   assign c[8]   = grp_g1 | (grp_p1 & grp_g0) | (grp_p1 & grp_p0 & Cin);

   assign c[5]   = g[4] | (p[4] & c[4]);
   assign c[6]   = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
   assign c[7]   = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
   assign grp_g1 = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
   assign grp_p1 = &p[7:4];

   assign Y    = p ^ c[7:0];
   assign Cout = c[8];
   assign Ovf  = c[8] ^ c[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y_q    <= 8'h00;
         Cout_q <= 1'b0;
         Ovf_q  <= 1'b0;
      end else begin
         Y_q    <= Y;
         Cout_q <= Cout;
         Ovf_q  <= Ovf;
      end
   end

endmodule

// File: tb/tb_eb_cla_adder.sv
`timescale 1ns/1ps
// Self-checking bench for eb_cla_adder: directed vectors, register/reset timing, exhaustive sweep.
module tb_eb_cla_adder;

   logic       clk;
   logic       rst_n;
   logic [7:0] A, B;
   logic       Cin;
   logic [7:0] Y, Y_q;
   logic       Cout, Ovf, Cout_q, Ovf_q;

   int tests_run;
   int tests_failed;

   eb_cla_adder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .Cin    (Cin),
      .Y      (Y),
      .Cout   (Cout),
      .Ovf    (Ovf),
      .Y_q    (Y_q),
      .Cout_q (Cout_q),
      .Ovf_q  (Ovf_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: {Ovf, Cout, Y}; overflow when like-signed operands give an opposite-signed sum.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic ci);
      logic [8:0] s;
      logic       v;
      s = {1'b0, a} + {1'b0, b} + {8'h00, ci};
      v = (a[7] == b[7]) && (s[7] != a[7]);
      return {v, s};
   endfunction

   logic [9:0] exp_v;
   logic [9:0] prev_v;
   logic [16:0] vec;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      A = 8'd0; B = 8'd0; Cin = 1'b0;

      #2;
      check("rst_Y_q",    {24'd0, Y_q},    32'h00);
      check("rst_Cout_q", {31'd0, Cout_q}, 32'h0);
      check("rst_Ovf_q",  {31'd0, Ovf_q},  32'h0);

      // Directed combinational vectors, hand-computed {Ovf,Cout,Y}
      A = 8'd0;   B = 8'd0;   Cin = 1'b0; #10;
      check("zero",      {22'd0, Ovf, Cout, Y}, {22'd0, 1'b0, 1'b0, 8'd0});
      A = 8'd1;   B = 8'd2;   Cin = 1'b0; #10;
      check("1+2",       {22'd0, Ovf, Cout, Y}, {22'd0, 1'b0, 1'b0, 8'd3});
      A = 8'd15;  B = 8'd15;  Cin = 1'b1; #10;
      check("15+15+1",   {22'd0, Ovf, Cout, Y}, {22'd0, 1'b0, 1'b0, 8'd31});
      A = 8'd100; B = 8'd50;  Cin = 1'b0; #10;
      check("100+50",    {22'd0, Ovf, Cout, Y}, {22'd0, 1'b1, 1'b0, 8'd150});
      A = 8'd255; B = 8'd0;   Cin = 1'b1; #10;
      check("255+0+1",   {22'd0, Ovf, Cout, Y}, {22'd0, 1'b0, 1'b1, 8'd0});
      A = 8'd128; B = 8'd128; Cin = 1'b0; #10;
      check("128+128",   {22'd0, Ovf, Cout, Y}, {22'd0, 1'b1, 1'b1, 8'd0});
      A = 8'd127; B = 8'd1;   Cin = 1'b0; #10;
      check("127+1",     {22'd0, Ovf, Cout, Y}, {22'd0, 1'b1, 1'b0, 8'd128});
      check("rst_hold_Y_q", {24'd0, Y_q}, 32'h00);

      // Register latency and asynchronous reset
      @(negedge clk);
      rst_n = 1'b1;
      A = 8'd128; B = 8'd128; Cin = 1'b0;
      @(posedge clk); #1;
      check("reg_128_flags", {30'd0, Ovf_q, Cout_q}, 32'h3);
      A = 8'd1; B = 8'd2; Cin = 1'b0;
      @(posedge clk); #1;
      check("reg_Y_q_3", {24'd0, Y_q}, 32'd3);
      check("reg_flags_0", {30'd0, Ovf_q, Cout_q}, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_Y_q",   {24'd0, Y_q},   32'h00);
      check("async_rst_flags", {30'd0, Ovf_q, Cout_q}, 32'h0);
      check("async_rst_Y",     {24'd0, Y},     32'd3);
      @(posedge clk); #1;
      check("rst_held_edge", {24'd0, Y_q}, 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_Y_q", {24'd0, Y_q}, 32'd3);

      // Exhaustive combinational sweep
      for (int i = 0; i < 131072; i++) begin
         vec = i[16:0];
         Cin = vec[16];
         A   = vec[15:8];
         B   = vec[7:0];
         #1;
         exp_v = model(A, B, Cin);
         check("sweep", {22'd0, Ovf, Cout, Y}, {22'd0, exp_v});
      end

      // Registered outputs track the previous cycle's combinational result
      @(posedge clk); #1;
      for (int k = 0; k < 300; k++) begin
         A   = 8'($urandom_range(0, 255));
         B   = 8'($urandom_range(0, 255));
         Cin = 1'($urandom_range(0, 1));
         prev_v = model(A, B, Cin);
         @(posedge clk); #1;
         check("reg_track", {22'd0, Ovf_q, Cout_q, Y_q}, {22'd0, prev_v});
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/eb_cla_adder.md
# eb_cla_adder

8-bit two-level carry-lookahead adder with a combinational sum path and a registered copy of the result. Two 4-bit lookahead groups compute per-bit generate/propagate terms. A second-level lookahead unit derives the group carries, so no carry ripples between bits. It sits in the datapath as a fast unsigned/two's-complement adder: consumers that tolerate one cycle of latency use the registered outputs.

## Interface
- No parameters; width fixed at 8 bits.
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for the output registers
- rst_n  input  1  asynchronous active-low reset
- A  input  8  operand A
- B  input  8  operand B
- Cin  input  1  carry into bit 0
- Y  output  8  combinational sum, (A + B + Cin) mod 256
- Cout  output  1  combinational carry out of bit 7
- Ovf  output  1  combinational signed overflow, C8 XOR C7
- Y_q  output  8  Y registered on clk
- Cout_q  output  1  Cout registered on clk
- Ovf_q  output  1  Ovf registered on clk

## Operation
- Per bit i (0..7):
  - g[i] = A[i] & B[i]
  - p[i] = A[i] ^ B[i]
- Group 0 (bits 3:0), carries computed in lookahead form from Cin, not chained:
  - c1 = g0 | p0·Cin
  - c2 = g1 | p1·g0 | p1·p0·Cin
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·Cin
  - group terms G0 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 and P0 = p3·p2·p1·p0
- Group 1 (bits 7:4): same equations with carry-in C4.
  - Produces internal c5..c7 plus G1 and P1.
- Second-level lookahead:
  - C4 = G0 | P0·Cin
  - C8 = G1 | P1·G0 | P1·P0·Cin
- Sum and flag outputs:
  - Y[i] = p[i] ^ c[i], with c0 = Cin
  - Cout = C8
  - Ovf = C8 ^ c7
- Arithmetic rules:
  - {Cout, Y} equals the 9-bit unsigned value A + B + Cin exactly.
  - No saturation; results wrap mod 256.
- Y, Cout and Ovf are purely combinational.
  - They depend only on A, B and Cin, never on clk or rst_n.
- Registered outputs:
  - Y_q, Cout_q and Ovf_q capture Y, Cout and Ovf on every rising clk edge while rst_n = 1.
  - No enable input; the registers load every cycle.

## Timing
- Combinational path: Y, Cout and Ovf settle within one propagation delay of any input change.
  - The critical path is two lookahead levels deep, independent of operand values.
- Registered path latency: one cycle.
  - The value present at A/B/Cin just before rising edge k appears on Y_q/Cout_q/Ovf_q after edge k.
- Reset:
  - rst_n = 0 forces Y_q = 8'h00, Cout_q = 0 and Ovf_q = 0 immediately, with no clock required.
  - Reset does not affect the combinational outputs.
- Reset deasserted mid-operation: the first rising edge after rst_n rises loads the current sum. No stale value is retained.
- Reset asserted concurrently with a clock edge: reset wins and the registers hold zero.
- No handshake and no state machine; every cycle is independent.

## Test plan
- Basic sums, combinational outputs checked 10 ns after input change (no clock needed):
  - A=0, B=0, Cin=0 -> Y=0, Cout=0, Ovf=0
  - A=1, B=2, Cin=0 -> Y=3, Cout=0
- Group carry and signed overflow:
  - A=15, B=15, Cin=1 -> Y=31, Cout=0 (exercises the C4 group carry)
  - A=100, B=50, Cin=0 -> Y=150, Cout=0, Ovf=1 (positive + positive gives a negative signed result)
- Full propagate chain:
  - A=255, B=0, Cin=1 -> Y=0, Cout=1, Ovf=0 (carry crosses all 8 bits via P0·P1)
  - A=128, B=128, Cin=0 -> Y=0, Cout=1, Ovf=1
- Register latency and reset:
  - Apply A=1, B=2, then clock once -> Y_q=3 after the edge.
  - Assert rst_n=0 between edges -> Y_q=0, Cout_q=0, Ovf_q=0 immediately while Y stays 3.
  - Release rst_n and clock -> Y_q=3.
- Exhaustive sweep: all 2^17 combinations of A, B and Cin -> {Cout, Y} equals A+B+Cin and Ovf matches the signed-overflow rule.
  - Registered outputs match the previous cycle's combinational values throughout.
